// File: rtl/dac_sequence_controller.sv
// Steps the signal composer's sequence input through a BRAM table of per-step values,
// holding each entry for a programmable number of clock cycles, one-shot or looping.
module dac_sequence_controller #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic                  continuous,
   input  logic [31:0]           cycles_per_step,
   input  logic [ADDR_WIDTH-1:0] num_steps,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [31:0]           bram_rdata,
   output logic signed [15:0]    seq_out,
   output logic                  dyn_offset_disable,
   output logic                  disable_dac,
   output logic                  step_strobe,
   output logic [ADDR_WIDTH-1:0] step_index,
   output logic                  running,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q;
   logic [31:0]             cps_q;
   logic [31:0]             count_q;
   logic [ADDR_WIDTH-1:0]   lastStep_q;
   logic                    cont_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   index_q;
   logic signed [15:0]      seq_q;
   logic                    offsetDis_q;
   logic                    dacDis_q;
   logic                    strobe_q;
   logic                    running_q;
   logic                    done_q;

   logic [ADDR_WIDTH-1:0]   addr_d;
   logic                    stepEnd;
   logic                    lastEntry;

   // Address advance wraps at the latched table length, not at the BRAM size.
   always_comb begin
      addr_d    = (addr_q == lastStep_q) ? '0 : addr_q + 1'b1;
      stepEnd   = (count_q == cps_q - 32'd1);
      lastEntry = (index_q == lastStep_q);
   end

   // Single FSM: reset and enable=0 both force the idle outputs, taking priority
   // over trigger and step boundaries. All outputs are registered here.
   always_ff @(posedge clk) begin
      if (!aresetn || !enable) begin
         state_q     <= IDLE;
         count_q     <= '0;
         addr_q      <= '0;
         index_q     <= '0;
         seq_q       <= '0;
         offsetDis_q <= 1'b1;
         dacDis_q    <= 1'b0;
         strobe_q    <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         if (!aresetn) begin
            cps_q      <= 32'd2;
            lastStep_q <= '0;
            cont_q     <= 1'b0;
         end
      end else begin
         strobe_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q    <= ARMED;
               cps_q      <= (cycles_per_step < 32'd2) ? 32'd2 : cycles_per_step;
               lastStep_q <= (num_steps == '0) ? '0 : num_steps - 1'b1;
               cont_q     <= continuous;
            end
            ARMED: begin
               if (trigger) begin
                  state_q     <= RUN;
                  seq_q       <= bram_rdata[15:0];
                  offsetDis_q <= bram_rdata[16];
                  dacDis_q    <= bram_rdata[17];
                  index_q     <= '0;
                  strobe_q    <= 1'b1;
                  count_q     <= '0;
                  addr_q      <= addr_d;
                  running_q   <= 1'b1;
               end
            end
            RUN: begin
               if (!stepEnd) begin
                  count_q <= count_q + 32'd1;
               end else if (lastEntry && !cont_q) begin
                  // One-shot end: drop straight to idle outputs with no strobe.
                  state_q     <= DONE;
                  count_q     <= '0;
                  addr_q      <= '0;
                  index_q     <= '0;
                  seq_q       <= '0;
                  offsetDis_q <= 1'b1;
                  dacDis_q    <= 1'b0;
                  running_q   <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  seq_q       <= bram_rdata[15:0];
                  offsetDis_q <= bram_rdata[16];
                  dacDis_q    <= bram_rdata[17];
                  index_q     <= addr_q;
                  strobe_q    <= 1'b1;
                  count_q     <= '0;
                  addr_q      <= addr_d;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bram_addr          = addr_q;
   assign seq_out            = seq_q;
   assign dyn_offset_disable = offsetDis_q;
   assign disable_dac        = dacDis_q;
   assign step_strobe        = strobe_q;
   assign step_index         = index_q;
   assign running            = running_q;
   assign done               = done_q;

endmodule

// File: tb/tb_dac_sequence_controller.sv
// Scoreboard bench for dac_sequence_controller: expected strobes (cycle, value, flags,
// index) are queued when a run is started and popped by an independent monitor.
module tb_dac_sequence_controller;

   localparam int AW = 14;

   logic          clk;
   logic          aresetn;
   logic          enable;
   logic          trigger;
   logic          continuous;
   logic [31:0]   cycles_per_step;
   logic [AW-1:0] num_steps;
   logic [AW-1:0] bram_addr;
   logic [31:0]   bram_rdata;
   logic signed [15:0] seq_out;
   logic          dyn_offset_disable;
   logic          disable_dac;
   logic          step_strobe;
   logic [AW-1:0] step_index;
   logic          running;
   logic          done;

   logic [15:0]   seqU;
   assign seqU = seq_out;

   typedef struct {
      longint      cyc;
      logic [15:0] value;
      logic        ofs;
      logic        dac;
      int          idx;
   } exp_t;

   exp_t   sbQ[$];
   exp_t   lastExp;
   bit     haveLast;
   longint cyc;
   int     checks;
   int     failures;
   logic [31:0] mem [0:15];

   dac_sequence_controller #(.ADDR_WIDTH(AW)) dut (
      .clk                (clk),
      .aresetn            (aresetn),
      .enable             (enable),
      .trigger            (trigger),
      .continuous         (continuous),
      .cycles_per_step    (cycles_per_step),
      .num_steps          (num_steps),
      .bram_addr          (bram_addr),
      .bram_rdata         (bram_rdata),
      .seq_out            (seq_out),
      .dyn_offset_disable (dyn_offset_disable),
      .disable_dac        (disable_dac),
      .step_strobe        (step_strobe),
      .step_index         (step_index),
      .running            (running),
      .done               (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency BRAM model
   always @(posedge clk) bram_rdata <= mem[bram_addr[3:0]];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, actual, actual, expected, expected, cyc);
      end
   endtask

   // Monitor: every strobe pops one expectation; between strobes the outputs must hold.
   always @(negedge clk) begin
      if (step_strobe) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            lastExp = sbQ.pop_front();
            checkOutput("strobe_cycle", 32'(cyc), 32'(lastExp.cyc));
            checkOutput("strobe_seq", {16'd0, seqU}, {16'd0, lastExp.value});
            checkOutput("strobe_ofs", {31'd0, dyn_offset_disable}, {31'd0, lastExp.ofs});
            checkOutput("strobe_dac", {31'd0, disable_dac}, {31'd0, lastExp.dac});
            checkOutput("strobe_index", {18'd0, step_index}, 32'(lastExp.idx));
            haveLast = 1'b1;
         end
      end else if (running && haveLast) begin
         checkOutput("hold_seq", {16'd0, seqU}, {16'd0, lastExp.value});
         checkOutput("hold_ofs", {31'd0, dyn_offset_disable}, {31'd0, lastExp.ofs});
         checkOutput("hold_index", {18'd0, step_index}, 32'(lastExp.idx));
      end
      if (!running) haveLast = 1'b0;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag, input bit expDone);
      checkOutput({tag, "_seq"}, {16'd0, seqU}, 32'd0);
      checkOutput({tag, "_ofs"}, {31'd0, dyn_offset_disable}, 32'd1);
      checkOutput({tag, "_dac"}, {31'd0, disable_dac}, 32'd0);
      checkOutput({tag, "_strobe"}, {31'd0, step_strobe}, 32'd0);
      checkOutput({tag, "_index"}, {18'd0, step_index}, 32'd0);
      checkOutput({tag, "_addr"}, {18'd0, bram_addr}, 32'd0);
      checkOutput({tag, "_running"}, {31'd0, running}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, expDone});
   endtask

   // Arms from IDLE, triggers on the first ARMED cycle and queues 'count' expected steps.
   task automatic applyStimulus(input int unsigned cpsIn, input int nIn, input bit cont,
                                input int count, output int unsigned cpsM);
      int     nM;
      longint trig;
      exp_t   e;
      cpsM = (cpsIn < 2) ? 2 : cpsIn;
      nM   = (nIn == 0) ? 1 : nIn;
      cycles_per_step = cpsIn;
      num_steps       = AW'(nIn);
      continuous      = cont;
      enable          = 1'b1;
      trigger         = 1'b0;
      tick();
      trigger = 1'b1;
      trig    = cyc + 1;
      for (int k = 0; k < count; k++) begin
         e.idx   = k % nM;
         e.cyc   = trig + longint'(k) * longint'(cpsM);
         e.value = mem[e.idx][15:0];
         e.ofs   = mem[e.idx][16];
         e.dac   = mem[e.idx][17];
         sbQ.push_back(e);
      end
      tick();
      trigger = 1'b0;
   endtask

   task automatic waitDrain(input int maxCycles);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
   endtask

   task automatic abortRun(input string tag);
      enable = 1'b0;
      tick();
      checkIdle(tag, 1'b0);
   endtask

   // After the last queued step of a one-shot run: exact DONE timing, trigger ignored.
   task automatic finishOneShot(input int unsigned cpsM, input int maxCycles);
      waitDrain(maxCycles);
      repeat (cpsM - 1) tick();
      checkOutput("last_step_running", {31'd0, running}, 32'd1);
      checkOutput("last_step_not_done", {31'd0, done}, 32'd0);
      tick();
      checkIdle("done", 1'b1);
      trigger = 1'b1;
      tick();
      tick();
      checkOutput("done_ignores_trigger", {31'd0, done}, 32'd1);
      trigger = 1'b0;
      abortRun("after_done");
   endtask

   initial begin
      int unsigned cpsM;
      int          nR;
      int unsigned cR;
      bit          contR;
      int          kR;

      checks     = 0;
      failures   = 0;
      cyc        = 0;
      haveLast   = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      aresetn         = 1'b0;
      enable          = 1'b0;
      trigger         = 1'b0;
      continuous      = 1'b0;
      cycles_per_step = 32'd0;
      num_steps       = '0;
      tick();
      tick();
      checkIdle("reset", 1'b0);
      aresetn = 1'b1;
      tick();

      // One-shot table {100, -200 w/ offset-disable, 300 w/ DAC-disable}
      mem[0] = 32'd100;
      mem[1] = {14'h3abc, 1'b0, 1'b1, 16'hff38};
      mem[2] = {14'h0, 1'b1, 1'b0, 16'd300};
      applyStimulus(4, 3, 1'b0, 3, cpsM);
      finishOneShot(cpsM, 40);

      // Continuous cps=2, N=2 {1,2}: 20 cycles, seamless wrap
      mem[0] = 32'd1;
      mem[1] = 32'd2;
      applyStimulus(2, 2, 1'b1, 10, cpsM);
      waitDrain(40);
      abortRun("cont_abort");

      // cycles_per_step=0 clamps to 2 with N=1 continuous
      mem[0] = 32'h0003_8001;
      applyStimulus(0, 1, 1'b1, 6, cpsM);
      waitDrain(30);
      abortRun("clamp_cps_abort");

      // num_steps=0 behaves as a single step
      mem[0] = 32'h0001_7fff;
      applyStimulus(3, 0, 1'b0, 1, cpsM);
      finishOneShot(cpsM, 20);

      // Abort mid 10-cycle step, then restart from entry 0
      mem[0] = 32'd11;
      mem[1] = 32'h0002_0016;
      mem[2] = 32'd33;
      applyStimulus(10, 3, 1'b1, 2, cpsM);
      waitDrain(40);
      repeat (4) tick();
      abortRun("mid_step_abort");
      applyStimulus(10, 3, 1'b1, 1, cpsM);
      waitDrain(20);
      abortRun("restart_abort");

      // Sync reset mid-RUN with trigger held high throughout
      applyStimulus(4, 3, 1'b1, 2, cpsM);
      waitDrain(30);
      trigger = 1'b1;
      tick();
      aresetn = 1'b0;
      tick();
      checkIdle("sync_reset", 1'b0);
      aresetn = 1'b1;
      begin
         exp_t e;
         longint trig;
         trig = cyc + 2;
         for (int k = 0; k < 4; k++) begin
            e.idx   = k % 3;
            e.cyc   = trig + longint'(k) * 4;
            e.value = mem[e.idx][15:0];
            e.ofs   = mem[e.idx][16];
            e.dac   = mem[e.idx][17];
            sbQ.push_back(e);
         end
      end
      tick();
      checkOutput("armed_not_running", {31'd0, running}, 32'd0);
      waitDrain(40);
      trigger = 1'b0;
      abortRun("post_reset_abort");

      // Config change during RUN is ignored until re-arming
      applyStimulus(4, 3, 1'b0, 3, cpsM);
      cycles_per_step = 32'd8;
      finishOneShot(cpsM, 40);
      applyStimulus(8, 3, 1'b0, 3, cpsM);
      finishOneShot(cpsM, 60);

      // Randomized runs against the table model
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < 8; i++) mem[i] = $urandom;
         nR    = $urandom_range(0, 6);
         cR    = $urandom_range(0, 6);
         contR = 1'($urandom_range(0, 1));
         if (contR) begin
            kR = $urandom_range(1, 3 * ((nR == 0) ? 1 : nR) + 1);
            applyStimulus(cR, nR, 1'b1, kR, cpsM);
            waitDrain(kR * 8 + 20);
            abortRun("rand_abort");
         end else begin
            applyStimulus(cR, nR, 1'b0, (nR == 0) ? 1 : nR, cpsM);
            finishOneShot(cpsM, 80);
         end
      end

      tick();
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dac_sequence_controller.md
Name: dac_sequence_controller

Overview:
- Steps the DAC composer's sequence input through a table of per-step values held in a block RAM.
- Per step it drives a signed 16-bit sequence value plus the dynamic-offset-disable and DAC-disable controls. Every step lasts a programmable number of clock cycles.
- Sits between the configuration registers / sequence BRAM and the signal composer (feeds its seq, dyn_offset_disable and disable_dac inputs).
- Supports one-shot and continuous (looping) playback, armed by enable and started by trigger.

Parameters:
- ADDR_WIDTH, 14, width of the BRAM word address; the table holds up to 2^ADDR_WIDTH steps.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  reset. Synchronous, active-low.
- enable  in  1  level. 1 arms or keeps the sequencer; 0 aborts it to IDLE.
- trigger  in  1  level, sampled in ARMED. Starts playback.
- continuous  in  1  1 = loop the table forever; 0 = play once.
- cycles_per_step  in  32  clock cycles per step. Unsigned; values below 2 are clamped to 2.
- num_steps  in  ADDR_WIDTH  steps in the table. 0 is treated as 1.
- bram_addr  out  ADDR_WIDTH  BRAM read address (registered).
- bram_rdata  in  32  BRAM read data, one-cycle latency.
  - [15:0] value, signed.
  - [16] offset-disable flag.
  - [17] DAC-disable flag.
  - Remaining bits ignored.
- seq_out  out  16  signed sequence value to the composer.
- dyn_offset_disable  out  1  to the composer.
- disable_dac  out  1  to the composer.
- step_strobe  out  1  one-cycle pulse on every output update.
- step_index  out  ADDR_WIDTH  index of the step currently driven.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (aresetn=0 at a clk edge) and any abort force state IDLE and the idle output values:
  - seq_out=0, dyn_offset_disable=1, disable_dac=0.
  - step_strobe=0, step_index=0, bram_addr=0, running=0, done=0.
  - Cycle counter cleared.
  - This applies mid-RUN as well.
- States:
  - IDLE -> ARMED on enable=1.
  - ARMED -> RUN on trigger=1.
  - RUN -> DONE at the end of the last step when continuous=0.
  - DONE -> IDLE on enable=0.
  - Any state -> IDLE on enable=0 (takes effect the next cycle).
- IDLE -> ARMED edge:
  - Latch cps = max(cycles_per_step, 2), N = max(num_steps, 1) and continuous.
  - Changes to these inputs after arming are ignored until the next arming.
  - bram_addr stays 0. Trigger is only sampled from the first ARMED cycle onward.
- ARMED with trigger=1, at that edge:
  - Load seq_out/flags from bram_rdata (entry 0).
  - step_index=0, step_strobe=1, counter=0.
  - bram_addr=1 mod N.
  - Outputs therefore change the cycle after trigger is sampled.
- RUN:
  - Counter increments each cycle.
  - When counter=cps-1: counter=0, load outputs from bram_rdata (entry at bram_addr), step_index=bram_addr, step_strobe=1, bram_addr=(bram_addr+1) mod N.
  - The minimum cps of 2 guarantees the BRAM data is valid when loaded.
- End of table: when counter=cps-1 and step_index=N-1:
  - continuous=1: wrap to entry 0 seamlessly, with no gap cycle.
  - continuous=0: go to DONE. Outputs return to idle values at that edge and no strobe is issued.
- N=1 with continuous=1: entry 0 is reloaded every cps cycles, and step_strobe pulses each time.
- Simultaneous events:
  - enable=0 wins over trigger and over a step boundary.
  - In DONE, trigger is ignored; re-arming requires enable to drop and rise again.
- Arithmetic: the counter is 32-bit and never overflows, because cps <= 2^32-1. Address increment wraps modulo N, not modulo 2^ADDR_WIDTH.

Test Plan:
- Reset then one-shot playback. cps=4, N=3, entries {100, -200 with offset-disable, 300 with DAC-disable}, enable=1, trigger on the 3rd cycle.
  - seq_out = 100, -200, 300 for 4 cycles each, with flags per entry.
  - step_strobe pulses at t, t+4, t+8.
  - Idle values and done=1 from t+12.
- Continuous loop, cps=2, N=2, entries {1, 2}: seq_out alternates 1,1,2,2,1,1,... with no gap at the wrap. Sample 20 cycles.
- Clamp cases:
  - cycles_per_step=0 with N=1 continuous: strobe every 2 cycles.
  - num_steps=0 behaves as 1.
- Abort: enable=0 mid-step of a 10-cycle step.
  - Next cycle: seq_out=0, dyn_offset_disable=1, running=0, bram_addr=0.
  - Re-enable plus trigger restarts at entry 0.
- Sync reset mid-RUN: aresetn=0 for 1 cycle gives idle values on the following cycle. Trigger held high through reset has no effect until the controller is re-armed (earliest one cycle after entering ARMED).
- Config change during RUN: write cycles_per_step=8 while running with cps=4. Step length stays 4 until DONE, and becomes 8 after re-arming.
